// File: rtl/multi_port_reg_collection_pkg.sv
// Shared types and default sizing for the multi-port register collection.
package multi_port_reg_collection_pkg;

  localparam int unsigned DEF_DEPTH     = 32;
  localparam int unsigned DEF_CHANWIDTH = 32;
  localparam int unsigned DEF_NWR       = 2;

  typedef enum logic [1:0] {
    SHIFT_HOLD = 2'b00,
    SHIFT_FWD  = 2'b01,
    SHIFT_REV  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_t;

  // Positional source chosen for one entry once collapse/shift ops are resolved.
  typedef enum logic [1:0] {
    POS_HOLD = 2'b00,
    POS_FWD  = 2'b01,
    POS_REV  = 2'b10,
    POS_ZERO = 2'b11
  } pos_sel_t;

endpackage

// File: rtl/multi_port_reg_collection_if.sv
// Control/status bundle between the queue control unit and the register collection.
interface multi_port_reg_collection_if
  import multi_port_reg_collection_pkg::*;
#(
  parameter int unsigned p_depth     = DEF_DEPTH,
  parameter int unsigned p_nwr       = DEF_NWR,
  parameter int unsigned p_chanwidth = DEF_CHANWIDTH,
  parameter int unsigned p_ptrwidth  = $clog2(p_depth),
  parameter int unsigned p_bitwidth  = p_ptrwidth + p_chanwidth
);

  logic [p_nwr-1:0]                   wr_en;
  logic [p_nwr-1:0][p_ptrwidth-1:0]   wr_idx;
  logic [p_nwr-1:0][p_bitwidth-1:0]   wr_data_in;
  logic [p_depth-1:0][1:0]            shift_op;
  logic                               collapse_en;
  logic [p_ptrwidth-1:0]              collapse_idx;
  logic                               clr_en;
  logic [p_ptrwidth-1:0]              clr_idx;
  logic                               flush;
  logic [p_depth-1:0][p_bitwidth-1:0] data_out;
  logic [p_depth-1:0]                 valid_out;
  logic [p_ptrwidth:0]                count;
  logic                               full;
  logic                               empty;
  logic                               wr_conflict;

  modport master (
    output wr_en, wr_idx, wr_data_in, shift_op, collapse_en, collapse_idx,
           clr_en, clr_idx, flush,
    input  data_out, valid_out, count, full, empty, wr_conflict
  );

  modport slave (
    input  wr_en, wr_idx, wr_data_in, shift_op, collapse_en, collapse_idx,
           clr_en, clr_idx, flush,
    output data_out, valid_out, count, full, empty, wr_conflict
  );

endinterface

// File: rtl/multi_port_reg_collection_entry.sv
// One storage entry: flush > positional move > clear > write, async active-low reset.
module mp_entry_reg
  import multi_port_reg_collection_pkg::*;
#(
  parameter int unsigned p_bitwidth = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  pos_sel_t              pos_sel,
  input  logic [p_bitwidth-1:0] fwd_data,
  input  logic                  fwd_valid,
  input  logic [p_bitwidth-1:0] rev_data,
  input  logic                  rev_valid,
  input  logic                  clr,
  input  logic                  wr_hit,
  input  logic [p_bitwidth-1:0] wr_data,
  output logic [p_bitwidth-1:0] data,
  output logic                  valid,
  output logic                  valid_next
);

  logic [p_bitwidth-1:0] data_next;

  always_comb begin
    data_next  = data;
    valid_next = valid;
    if (flush) begin
      valid_next = 1'b0;
    end else begin
      case (pos_sel)
        POS_FWD:  begin data_next = fwd_data; valid_next = fwd_valid; end
        POS_REV:  begin data_next = rev_data; valid_next = rev_valid; end
        POS_ZERO: begin data_next = '0;       valid_next = 1'b0;      end
        default:  ;
      endcase
      if (clr)
        valid_next = 1'b0;
      if (wr_hit) begin
        data_next  = wr_data;
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= data_next;
      valid <= valid_next;
    end
  end

endmodule

// File: rtl/multi_port_reg_collection.sv
// Shifting/collapsing register collection with p_nwr indexed write ports and occupancy status.
module multi_port_reg_collection
  import multi_port_reg_collection_pkg::*;
#(
  parameter int unsigned p_depth     = DEF_DEPTH,
  parameter int unsigned p_ptrwidth  = $clog2(p_depth),
  parameter int unsigned p_chanwidth = DEF_CHANWIDTH,
  parameter int unsigned p_bitwidth  = p_ptrwidth + p_chanwidth,
  parameter int unsigned p_nwr       = DEF_NWR
) (
  input logic                        clk,
  input logic                        rst,
  multi_port_reg_collection_if.slave bus
);

  localparam int unsigned p_cntwidth = p_ptrwidth + 1;

  pos_sel_t              pos_sel     [p_depth];
  logic [p_bitwidth-1:0] wr_data_sel [p_depth];
  logic [p_bitwidth-1:0] data_q      [p_depth];
  logic [p_depth-1:0]    wr_hit;
  logic [p_depth-1:0]    valid_q;
  logic [p_depth-1:0]    valid_nxt;
  logic [p_cntwidth-1:0] count_q;
  logic [p_cntwidth-1:0] count_nxt;

  // Collapse replaces every shift op; an out-of-range collapse leaves the array holding.
  always_comb begin
    for (int unsigned i = 0; i < p_depth; i++) begin
      pos_sel[i] = POS_HOLD;
      if (bus.collapse_en) begin
        if (32'(bus.collapse_idx) < p_depth && i >= 32'(bus.collapse_idx))
          pos_sel[i] = (i == p_depth - 1) ? POS_ZERO : POS_REV;
      end else begin
        case (shift_op_t'(bus.shift_op[i]))
          SHIFT_FWD: pos_sel[i] = POS_FWD;
          SHIFT_REV: pos_sel[i] = POS_REV;
          default:   pos_sel[i] = POS_HOLD;
        endcase
      end
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < p_depth; i++) begin
      wr_data_sel[i] = '0;
      for (int unsigned k = 0; k < p_nwr; k++) begin
        if (!wr_hit[i] && bus.wr_en[k] && 32'(bus.wr_idx[k]) == i) begin
          wr_hit[i]      = 1'b1;
          wr_data_sel[i] = bus.wr_data_in[k];
        end
      end
    end
  end

  always_comb begin
    bus.wr_conflict = 1'b0;
    for (int unsigned k = 0; k < p_nwr; k++)
      for (int unsigned j = k + 1; j < p_nwr; j++)
        if (bus.wr_en[k] && bus.wr_en[j] && bus.wr_idx[k] == bus.wr_idx[j])
          bus.wr_conflict = 1'b1;
  end

  for (genvar g = 0; g < p_depth; g++) begin : g_entry
    logic [p_bitwidth-1:0] fwd_data;
    logic [p_bitwidth-1:0] rev_data;
    logic                  fwd_valid;
    logic                  rev_valid;

    if (g == 0) begin : g_bottom
      assign fwd_data  = '0;
      assign fwd_valid = 1'b0;
    end else begin : g_fwd
      assign fwd_data  = data_q[g-1];
      assign fwd_valid = valid_q[g-1];
    end

    if (g == p_depth - 1) begin : g_top
      assign rev_data  = '0;
      assign rev_valid = 1'b0;
    end else begin : g_rev
      assign rev_data  = data_q[g+1];
      assign rev_valid = valid_q[g+1];
    end

    mp_entry_reg #(.p_bitwidth(p_bitwidth)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .pos_sel    (pos_sel[g]),
      .fwd_data   (fwd_data),
      .fwd_valid  (fwd_valid),
      .rev_data   (rev_data),
      .rev_valid  (rev_valid),
      .clr        (bus.clr_en && 32'(bus.clr_idx) == g),
      .wr_hit     (wr_hit[g]),
      .wr_data    (wr_data_sel[g]),
      .data       (data_q[g]),
      .valid      (valid_q[g]),
      .valid_next (valid_nxt[g])
    );

    assign bus.data_out[g] = data_q[g];
  end

  always_comb begin
    count_nxt = '0;
    for (int unsigned i = 0; i < p_depth; i++)
      count_nxt = count_nxt + p_cntwidth'(valid_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_nxt;
  end

  assign bus.valid_out = valid_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == p_cntwidth'(p_depth));
  assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_multi_port_reg_collection.sv
// Directed test-plan scenarios plus randomized traffic against a queue-based reference model.
module tb_multi_port_reg_collection;
  import multi_port_reg_collection_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NWR   = 2;
  localparam int unsigned CW    = 8;
  localparam int unsigned BW    = 10;

  typedef logic [BW:0] ent_t;  // {valid, data}

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_port_reg_collection_if #(.p_depth(DEPTH), .p_nwr(NWR), .p_chanwidth(CW)) bus ();

  multi_port_reg_collection #(.p_depth(DEPTH), .p_nwr(NWR), .p_chanwidth(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  ent_t        model [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    bus.wr_en        = '0;
    bus.wr_idx       = '0;
    bus.wr_data_in   = '0;
    bus.shift_op     = '0;
    bus.collapse_en  = 1'b0;
    bus.collapse_idx = '0;
    bus.clr_en       = 1'b0;
    bus.clr_idx      = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  function automatic logic expected_conflict();
    for (int k = 0; k < NWR; k++)
      for (int j = k + 1; j < NWR; j++)
        if (bus.wr_en[k] && bus.wr_en[j] && bus.wr_idx[k] == bus.wr_idx[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Next state from the rules: flush wins; otherwise move, then clear, then first-port-wins writes.
  task automatic model_edge();
    ent_t pre[$];
    ent_t nxt [DEPTH];
    bit   taken [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      pre.push_back(model[i]);
      taken[i] = 0;
    end
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) model[i][BW] = 1'b0;
      return;
    end
    if (bus.collapse_en) begin
      if (int'(bus.collapse_idx) < DEPTH) begin
        pre.delete(int'(bus.collapse_idx));
        pre.push_back('0);
      end
      for (int i = 0; i < DEPTH; i++) nxt[i] = pre[i];
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.shift_op[i] == 2'b01)      nxt[i] = (i == 0) ? ent_t'(0) : pre[i-1];
        else if (bus.shift_op[i] == 2'b10) nxt[i] = (i == DEPTH - 1) ? ent_t'(0) : pre[i+1];
        else                               nxt[i] = pre[i];
      end
    end
    if (bus.clr_en && int'(bus.clr_idx) < DEPTH) nxt[bus.clr_idx][BW] = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      if (bus.wr_en[k] && int'(bus.wr_idx[k]) < DEPTH && !taken[bus.wr_idx[k]]) begin
        nxt[bus.wr_idx[k]]   = {1'b1, bus.wr_data_in[k]};
        taken[bus.wr_idx[k]] = 1;
      end
    end
    for (int i = 0; i < DEPTH; i++) model[i] = nxt[i];
  endtask

  task automatic check_state(input string tag);
    logic [DEPTH-1:0] vv;
    int unsigned      cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      vv[i] = model[i][BW];
      cnt  += model[i][BW];
      check($sformatf("%s_data%0d", tag, i), bus.data_out[i], model[i][BW-1:0]);
    end
    check({tag, "_valid"}, bus.valid_out, vv);
    check({tag, "_count"}, bus.count, cnt);
    check({tag, "_full"},  bus.full,  cnt == DEPTH);
    check({tag, "_empty"}, bus.empty, cnt == 0);
  endtask

  // Inputs are already driven; check the combinational conflict flag, then take one edge.
  task automatic step(input string tag);
    #1;
    check({tag, "_conflict"}, bus.wr_conflict, expected_conflict());
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
    idle();
  endtask

  task automatic wr(input int port, input int idx, input logic [BW-1:0] d);
    bus.wr_en[port]      = 1'b1;
    bus.wr_idx[port]     = 2'(idx);
    bus.wr_data_in[port] = d;
  endtask

  task automatic fill(input logic [BW-1:0] d0, d1, d2, d3);
    wr(0, 0, d0); wr(1, 1, d1); step("fill_a");
    wr(0, 2, d2); wr(1, 3, d3); step("fill_b");
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_state("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    wr(0, 0, 10'h011); wr(1, 3, 10'h044);
    step("dual");
    check("dual_valid_const", bus.valid_out, 4'b1001);
    check("dual_count_const", bus.count, 2);

    wr(0, 2, 10'h0AA); wr(1, 2, 10'h0BB);
    #1;
    check("same_idx_conflict_const", bus.wr_conflict, 1'b1);
    step("same_idx");
    check("same_idx_e2_const", bus.data_out[2], 10'h0AA);
    check("same_idx_count_const", bus.count, 3);

    fill(10'h010, 10'h020, 10'h030, 10'h040);
    check("fill_full_const", bus.full, 1'b1);
    for (int i = 0; i < DEPTH; i++) bus.shift_op[i] = 2'b01;
    step("fwd");
    check("fwd_e0_const", bus.data_out[0], 10'h000);
    check("fwd_e3_const", bus.data_out[3], 10'h030);
    check("fwd_valid_const", bus.valid_out, 4'b1110);
    check("fwd_full_const", bus.full, 1'b0);

    fill(10'h00A, 10'h00B, 10'h00C, 10'h00D);
    bus.collapse_en = 1'b1; bus.collapse_idx = 2'd1;
    for (int i = 0; i < DEPTH; i++) bus.shift_op[i] = 2'b01;
    wr(0, 3, 10'h055);
    step("collapse1");
    check("collapse1_e1_const", bus.data_out[1], 10'h00C);
    check("collapse1_e3_const", bus.data_out[3], 10'h055);
    check("collapse1_count_const", bus.count, 4);
    bus.collapse_en = 1'b1; bus.collapse_idx = 2'd3;
    step("collapse3");
    check("collapse3_valid_const", bus.valid_out, 4'b0111);

    bus.clr_en = 1'b1; bus.clr_idx = 2'd2; wr(1, 2, 10'h077);
    step("clr_wr");
    check("clr_wr_e2_const", bus.data_out[2], 10'h077);
    bus.clr_en = 1'b1; bus.clr_idx = 2'd2;
    step("clr");
    check("clr_valid_const", bus.valid_out, 4'b0011);
    check("clr_data_const", bus.data_out[2], 10'h077);
    check("clr_count_const", bus.count, 2);

    bus.flush = 1'b1; wr(0, 0, 10'h3FF);
    step("flush_wr");
    check("flush_empty_const", bus.empty, 1'b1);

    fill(10'h101, 10'h202, 10'h303, 10'h0F4);
    for (int i = 0; i < DEPTH; i++) bus.shift_op[i] = 2'b11;
    step("rsvd");

    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NWR; k++) begin
        bus.wr_en[k]      = ($urandom_range(0, 3) != 0);
        bus.wr_idx[k]     = 2'($urandom);
        bus.wr_data_in[k] = 10'($urandom);
      end
      if ($urandom_range(0, 2) == 0) bus.shift_op = 8'($urandom);
      bus.collapse_en  = ($urandom_range(0, 5) == 0);
      bus.collapse_idx = 2'($urandom);
      bus.clr_en       = ($urandom_range(0, 4) == 0);
      bus.clr_idx      = 2'($urandom);
      bus.flush        = ($urandom_range(0, 24) == 0);
      step("rand");
    end

    fill(10'h111, 10'h222, 10'h333, 10'h044);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_valid", bus.valid_out, 4'b0000);
    check("async_rst_data", bus.data_out, '0);
    check("async_rst_count", bus.count, 0);
    check("async_rst_empty", bus.empty, 1'b1);
    check("async_rst_full", bus.full, 1'b0);
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_port_reg_collection.md
Name: multi_port_reg_collection

Overview:
- Next-generation register collection backing the shifting FIFO/ROB datapath.
- Each entry carries a valid bit.
- Adds p_nwr independent indexed write ports, collapse-on-remove compaction, single-entry clear, global flush, and registered occupancy/full/empty status.
- Sits under the queue control unit, which drives per-entry shift ops and write indices.

Parameters:
- p_depth, 32, number of entries (>=2).
- p_ptrwidth, $clog2(p_depth), entry index width.
- p_chanwidth, 32, payload width.
- p_bitwidth, p_ptrwidth+p_chanwidth, stored word width.
- p_nwr, 2, number of write ports (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1 x [p_nwr]  write port k request.
- wr_idx  in  p_ptrwidth x [p_nwr]  target entry of port k.
- wr_data_in  in  p_bitwidth x [p_nwr]  write data of port k.
- shift_op  in  2 x [p_depth]  per-entry op: 00 hold, 01 fwd, 10 rev, 11 reserved.
- collapse_en  in  1  remove entry collapse_idx and compact above it.
- collapse_idx  in  p_ptrwidth  entry to remove.
- clr_en  in  1  invalidate one entry.
- clr_idx  in  p_ptrwidth  entry to invalidate.
- flush  in  1  invalidate all entries.
- data_out  out  p_bitwidth x [p_depth]  registered entry data.
- valid_out  out  1 x [p_depth]  registered entry valid.
- count  out  p_ptrwidth+1  registered number of valid entries.
- full  out  1  count == p_depth.
- empty  out  1  count == 0.
- wr_conflict  out  1  combinational; two or more enabled ports share an index this cycle.

Behaviour:
- Reset (rst low, async): all data_out=0, valid_out=0, count=0, empty=1, full=0; released synchronously to clk by the integrator.
- All state updates on the rising clk edge; every op has one-cycle latency to outputs.

Per-entry next state, evaluated in this priority order:
1. flush: valid=0 for all entries; data holds.
2. Positional stage. If collapse_en, the per-entry shift_op for the whole array is ignored and replaced by:
   - i < collapse_idx: hold.
   - collapse_idx <= i < p_depth-1: take entry i+1 (data and valid).
   - Top entry: valid=0, data=0.
   - collapse_idx >= p_depth: no-op.
   Otherwise shift_op applies per entry:
   - fwd: entry i takes entry i-1; entry 0 takes data 0, valid 0.
   - rev: entry i takes entry i+1; top entry takes data 0, valid 0.
   - 11: treated as hold.
   Sources are always pre-edge values, so mixed ops in one cycle never chain.
3. clr_en: the entry at clr_idx (post-positional position) gets valid=0; data holds.
4. Writes: wr_idx addresses the post-positional position.
   - Entry takes wr_data_in and valid=1; a write overrides clear on the same entry.
   - Same-index conflict: the lowest-numbered port wins and wr_conflict=1 that cycle.
   - wr_idx >= p_depth is ignored.

Status:
- count is registered and equals the popcount of next valid; full and empty are derived from registered count.
- Flush plus write in the same cycle: flush wins, write dropped, count=0.
- No internal overflow check: writing a valid entry overwrites it, and count stays consistent because it is a popcount.

Decomposition:
- Package multi_port_reg_collection_pkg:
  - shift_op_t enum (SHIFT_HOLD=2'b00, SHIFT_FWD=2'b01, SHIFT_REV=2'b10, SHIFT_RSVD=2'b11).
  - Width helper localparams.
- Sub-module mp_entry_reg: one entry with async active-low reset.
  - Inputs: flush, positional select (hold/fwd/rev/zero), fwd/rev neighbour data+valid, clr, wr hit, wr data.
  - Outputs: data and valid.
- Top level holds: write-port arbitration (per-entry lowest-port priority encoder), collapse-to-op remap, popcount.

Test Plan (p_depth=4, p_nwr=2, p_chanwidth=8):
- Reset: assert rst=0 mid-cycle after filling entries → valid_out=0000, data_out all 0, count=0, empty=1 immediately, without waiting for an edge.
- Dual write: port0 idx0 data 0x11, port1 idx3 data 0x44 → next cycle valid=1001, count=2, wr_conflict=0. Then both ports idx2 (0xAA, 0xBB) → entry2=0xAA, wr_conflict=1, count=3.
- Fill and shift: fill entries 0..3 with 0x10,0x20,0x30,0x40 → full=1. All shift_op=fwd → entries 0..3 = {0,0x10,0x20,0x30}, valid=1110, count=3, full=0.
- Collapse with simultaneous write: from full {A,B,C,D}, collapse_idx=1 plus port0 write idx3 0x55 → {A,C,D,0x55}, valid=1111, count=4. collapse_idx=3 alone → entry3 invalid, count=3.
- Clear vs write: clr_idx=2 with port1 write idx2 0x77 → entry2=0x77, valid. clr_idx=2 alone next cycle → valid[2]=0, data still 0x77, count decremented.
- Flush with write: flush=1 plus port0 write idx0 → all valid=0, count=0, empty=1. Shift_op=11 on a full array → state unchanged.
